// File: rtl/histogram_accum.sv
// Histogram bin-update stage: clear sweep, then pipelined read-modify-write increment of bin[pixel].
// Port 2 of the bin RAM is read-only (rd_addr), port 1 is write-only; a one-deep forward covers back-to-back same-bin hits.
module histogram_accum #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_start,
  input  logic              frame_end,
  input  logic              pix_valid,
  input  logic [ADDR_W-1:0] pix_data,
  output logic              pix_ready,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              hist_ready,
  output logic              sat_flag,
  output logic [DATA_W-1:0] pix_count
);

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_ACCUM, S_FLUSH, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
  logic                s1_valid_q, s1_valid_d;
  logic [ADDR_W-1:0]   s1_addr_q, s1_addr_d;
  logic                fwd_valid_q, fwd_valid_d;
  logic [ADDR_W-1:0]   fwd_addr_q, fwd_addr_d;
  logic [DATA_W-1:0]   fwd_data_q, fwd_data_d;
  logic                sat_q, sat_d;
  logic [DATA_W-1:0]   cnt_q, cnt_d;
  logic                accept, s1_wr;
  logic [DATA_W-1:0]   base, incr;

  // The RAM read for this pixel was sampled on the edge that committed the previous write.
  assign base = (fwd_valid_q && (fwd_addr_q == s1_addr_q)) ? fwd_data_q : rd_data;
  assign incr = (base == '1) ? base : base + 1'b1;

  assign rd_addr    = pix_data;
  assign sat_flag   = sat_q;
  assign pix_count  = cnt_q;

  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    s1_valid_d  = 1'b0;
    s1_addr_d   = s1_addr_q;
    fwd_valid_d = 1'b0;
    fwd_addr_d  = s1_addr_q;
    sat_d       = sat_q;
    cnt_d       = cnt_q;
    wr_en       = 1'b0;
    wr_addr     = '0;
    wr_data     = '0;
    pix_ready   = 1'b0;
    busy        = 1'b0;
    hist_ready  = 1'b0;
    accept      = 1'b0;
    s1_wr       = 1'b0;

    case (state_q)
      S_IDLE: ;
      S_CLEAR: begin
        busy      = 1'b1;
        wr_en     = 1'b1;
        wr_addr   = clr_cnt_q;
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == '1) state_d = S_ACCUM;
      end
      S_ACCUM: begin
        busy      = 1'b1;
        pix_ready = 1'b1;
        accept    = pix_valid;
        s1_wr     = s1_valid_q && !frame_start;
        if (frame_end) state_d = S_FLUSH;
      end
      S_FLUSH: begin
        busy    = 1'b1;
        s1_wr   = s1_valid_q;
        state_d = S_DONE;
      end
      S_DONE: begin
        hist_ready = !frame_start;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (s1_wr) begin
      wr_en       = 1'b1;
      wr_addr     = s1_addr_q;
      wr_data     = incr;
      fwd_valid_d = 1'b1;
      if (base == '1) sat_d = 1'b1;
    end

    if (accept) begin
      s1_valid_d = 1'b1;
      s1_addr_d  = pix_data;
      if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
    end

    // A new frame always restarts the sweep from bin 0 and drops any in-flight pixel.
    if (frame_start) begin
      state_d     = S_CLEAR;
      clr_cnt_d   = '0;
      s1_valid_d  = 1'b0;
      fwd_valid_d = 1'b0;
      sat_d       = 1'b0;
      cnt_d       = '0;
    end
  end

  assign fwd_data_d = wr_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      clr_cnt_q   <= '0;
      s1_valid_q  <= 1'b0;
      s1_addr_q   <= '0;
      fwd_valid_q <= 1'b0;
      fwd_addr_q  <= '0;
      fwd_data_q  <= '0;
      sat_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      s1_valid_q  <= s1_valid_d;
      s1_addr_q   <= s1_addr_d;
      fwd_valid_q <= fwd_valid_d;
      fwd_addr_q  <= fwd_addr_d;
      fwd_data_q  <= fwd_data_d;
      sat_q       <= sat_d;
      cnt_q       <= cnt_d;
    end
  end

endmodule

// File: doc/histogram_accum.md
Name: histogram_accum

Overview:
- Histogram bin-update stage that sits directly upstream of the histogram dual-port bin RAM (1024 x 32).
- Accepts a stream of 10-bit pixel values and performs a pipelined read-modify-write increment of bin[pixel].
- Uses the RAM's second port as a dedicated read port and the first port as a dedicated write port.
- Provides a zero-clear sweep before each frame, same-bin hazard forwarding, saturation, and a frame-complete pulse for the downstream readout.

Parameters:
- ADDR_W, 10, bin index width; the RAM holds 2^ADDR_W bins.
- DATA_W, 32, bin counter width.

Ports:
- clk  in  1  single clock; also drives both RAM ports.
- rst  in  1  synchronous, active-high reset.
- frame_start  in  1  one-cycle pulse; start clear sweep and a new frame.
- frame_end  in  1  one-cycle pulse; last pixel of the frame has been presented.
- pix_valid  in  1  pix_data is valid this cycle.
- pix_data  in  ADDR_W  pixel value, equal to the bin index.
- pix_ready  out  1  high only in ACCUM; pixels offered while low are dropped.
- rd_addr  out  ADDR_W  to RAM port 2 address; RAM port 2 write enable is tied 0.
- rd_data  in  DATA_W  from RAM port 2 output; valid 1 cycle after rd_addr is sampled.
- wr_en  out  1  to RAM port 1 write enable.
- wr_addr  out  ADDR_W  to RAM port 1 address.
- wr_data  out  DATA_W  to RAM port 1 write data.
- busy  out  1  high in CLEAR, ACCUM and FLUSH.
- hist_ready  out  1  one-cycle pulse when the frame histogram is final.
- sat_flag  out  1  sticky: some bin saturated during this frame.
- pix_count  out  DATA_W  pixels accepted this frame; saturates at all-ones.

Behaviour:
- Reset values: state=IDLE, wr_en=0, wr_addr=0, wr_data=0, rd_addr=0, busy=0, hist_ready=0, sat_flag=0, pix_count=0, pix_ready=0, s1_valid=0, fwd_valid=0.
- RAM contents are not touched by reset.
- States:
  - IDLE -> CLEAR on frame_start.
  - CLEAR: write 0 to addresses 0..2^ADDR_W-1, one per cycle, using an internal counter. After writing the last address, go to ACCUM. The sweep takes exactly 1024 cycles. Entering CLEAR resets sat_flag and pix_count to 0.
  - ACCUM: pix_ready=1. On frame_end go to FLUSH. On frame_start, abort the frame: discard s1 (no write) and restart CLEAR at address 0.
  - FLUSH: lasts one cycle so the pending s1 write commits. Then go to DONE.
  - DONE: lasts one cycle, hist_ready=1, then go to IDLE.
- frame_start in FLUSH or DONE also restarts CLEAR; hist_ready is then not pulsed.
- frame_end outside ACCUM is ignored.
- Accept condition: pix_valid && state==ACCUM. This includes the cycle on which frame_end is high; that pixel is counted.
- rd_addr = pix_data combinationally.
- On accept, at the edge: s1_addr <= pix_data, s1_valid <= 1, and pix_count increments unless already all-ones.
- s1 cycle (the cycle after accept), combinational:
  - base = fwd_data if fwd_valid && fwd_addr==s1_addr, else rd_data.
  - wr_en=1, wr_addr=s1_addr, wr_data = (base==all-ones) ? base : base+1.
  - When base==all-ones, set sat_flag.
- Forwarding register: each edge, fwd_valid <= s1_valid, fwd_addr <= s1_addr, fwd_data <= wr_data.
  - A one-deep forward is sufficient. The read for pixel N is sampled on the same edge that commits pixel N-1's write; earlier writes are already visible in the RAM.
- Pixel-to-commit latency: 2 edges. Back-to-back same-bin pixels are sustained at 1 pixel/cycle with no stall.
- In CLEAR: wr_en=1, wr_data=0, wr_addr=counter, and fwd_valid is forced to 0 so stale counts are never forwarded.
- wr_en=0 in IDLE and DONE, and in ACCUM/FLUSH on cycles where s1_valid=0.
- Single write port, no contention: CLEAR and s1 writes never overlap because s1_valid is cleared on entry to CLEAR.

Test Plan:
- Reset, then frame_start -> busy rises next cycle; wr_en=1 for exactly 1024 cycles at addresses 0..1023 with wr_data=0; then pix_ready=1.
- After the clear, pixels 5,7,5 then frame_end -> bins 5=2, 7=1; hist_ready pulses once 2 cycles after frame_end; pix_count=3.
- 100 consecutive valid pixels all =9, no gaps -> bin 9=100; each wr_data increments by exactly 1 (forwarding path exercised).
- Pattern 3,4,3,4 with one idle cycle between pixels -> bins 3=2, 4=2; the forwarding mux is never selected.
- Preload bin 12 = 0xFFFFFFFE via a backdoor write after the clear, then two pixels =12 -> bin 12=0xFFFFFFFF and sat_flag=1.
- frame_start mid-ACCUM with s1 pending, and separately rst asserted mid-CLEAR -> no stale write reaches the RAM; after the abort the clear restarts at address 0; after rst all outputs return to their reset values and the state is IDLE.
